// File: rtl/pipe_pkg.sv
// Shared widths and field layout for the EX->MEM bundle carried by pipe_stage_chain.
// The control bit indices and payload offsets match the legacy EM register.
package pipe_pkg;

  localparam int EM_CTRL_W = 3;

  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_TO_REG = 1;
  localparam int CTRL_MEM_WRITE  = 2;

  localparam int EM_DATA_W = 69;

  // Payload layout, LSB first: write_reg, write_data, alu_result.
  localparam int WRITE_REG_LSB  = 0;
  localparam int WRITE_REG_W    = 5;
  localparam int WRITE_DATA_LSB = WRITE_REG_LSB + WRITE_REG_W;
  localparam int WRITE_DATA_W   = 32;
  localparam int ALU_RESULT_LSB = WRITE_DATA_LSB + WRITE_DATA_W;
  localparam int ALU_RESULT_W   = 32;

  typedef struct packed {
    logic [ALU_RESULT_W-1:0] alu_result;
    logic [WRITE_DATA_W-1:0] write_data;
    logic [WRITE_REG_W-1:0]  write_reg;
  } em_data_t;

endpackage

// File: rtl/pipe_slot.sv
// One register slot of the stage chain: valid + control + payload.
// An invalid slot always holds ctrl=0; its payload is kept as-is.
module pipe_slot #(
  parameter int CTRL_W = 3,
  parameter int DATA_W = 69
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              load,
  input  logic              src_valid,
  input  logic [CTRL_W-1:0] src_ctrl,
  input  logic [DATA_W-1:0] src_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_reg;
  logic [CTRL_W-1:0] ctrl_reg;
  logic [DATA_W-1:0] data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= '0;
      data_reg  <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= '0;
    end else if (load) begin
      // Loading from an empty source turns this slot into a bubble.
      valid_reg <= src_valid;
      ctrl_reg  <= src_valid ? src_ctrl : '0;
      if (src_valid) begin
        data_reg <= src_data;
      end
    end
  end

  assign valid = valid_reg;
  assign ctrl  = ctrl_reg;
  assign data  = data_reg;

endmodule

// File: rtl/pipe_stage_chain.sv
// DEPTH-deep inter-stage register chain with valid/ready backpressure, bubble
// collapsing and synchronous flush. Slot 0 faces the producer, slot DEPTH-1 the consumer.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int CTRL_W = EM_CTRL_W,
  parameter int DATA_W = EM_DATA_W,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  occupancy,
  output logic [DEPTH-1:0]  slot_valid
);

  logic [DEPTH-1:0]  v;
  logic [DEPTH-1:0]  rdy;
  logic [CTRL_W-1:0] slot_ctrl [DEPTH];
  logic [DATA_W-1:0] slot_data [DEPTH];

  logic             push;
  logic             pop;
  logic [CNT_W-1:0] occ_reg;
  logic [CNT_W-1:0] occ_next;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      // Slot gi can take new content unless it and every slot downstream are
      // full with the consumer stalled; written flat to avoid a bit-level loop.
      assign rdy[gi] = out_ready | ~(&v[DEPTH-1:gi]);

      if (gi == 0) begin : g_head
        pipe_slot #(
          .CTRL_W(CTRL_W),
          .DATA_W(DATA_W)
        ) u_slot (
          .clk      (clk),
          .rst_n    (rst_n),
          .flush    (flush),
          .load     (rdy[gi]),
          .src_valid(in_valid & in_ready),
          .src_ctrl (in_ctrl),
          .src_data (in_data),
          .valid    (v[gi]),
          .ctrl     (slot_ctrl[gi]),
          .data     (slot_data[gi])
        );
      end else begin : g_body
        pipe_slot #(
          .CTRL_W(CTRL_W),
          .DATA_W(DATA_W)
        ) u_slot (
          .clk      (clk),
          .rst_n    (rst_n),
          .flush    (flush),
          .load     (rdy[gi]),
          .src_valid(v[gi-1]),
          .src_ctrl (slot_ctrl[gi-1]),
          .src_data (slot_data[gi-1]),
          .valid    (v[gi]),
          .ctrl     (slot_ctrl[gi]),
          .data     (slot_data[gi])
        );
      end
    end
  endgenerate

  assign in_ready = rdy[0] & ~flush;

  assign push = in_valid & in_ready;
  assign pop  = v[DEPTH-1] & out_ready;

  // Bubbles never change the count, so occupancy only tracks push/pop.
  always_comb begin
    occ_next = occ_reg;
    if (flush) begin
      occ_next = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   occ_next = occ_reg + CNT_W'(1);
        2'b01:   occ_next = occ_reg - CNT_W'(1);
        default: occ_next = occ_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_reg <= '0;
    end else begin
      occ_reg <= occ_next;
    end
  end

  assign occupancy  = occ_reg;
  assign slot_valid = v;
  assign out_valid  = v[DEPTH-1];
  assign out_ctrl   = slot_ctrl[DEPTH-1];
  assign out_data   = slot_data[DEPTH-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain (DEPTH=2): a position-per-bundle queue model
// predicts handshakes and occupancy; a negedge monitor checks every output cycle.
module tb_pipe_stage_chain;

  localparam int D      = 2;
  localparam int CTRL_W = 3;
  localparam int DATA_W = 69;
  localparam int CNT_W  = $clog2(D + 1);

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  occupancy;
  logic [D-1:0]      slot_valid;

  pipe_stage_chain #(
    .DEPTH (D),
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy),
    .slot_valid(slot_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: each accepted bundle remembers which slot (0..D-1) it occupies.
  int                        pos_q[$];
  logic [CTRL_W+DATA_W-1:0]  exp_q[$];

  bit             fix_ctrl = 1'b0;
  logic [2:0]     fix_val  = 3'b000;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_out_valid();
    return (pos_q.size() > 0) && (pos_q[0] == D - 1);
  endfunction

  function automatic bit m_in_ready();
    return !flush && ((pos_q.size() < D) || out_ready);
  endfunction

  function automatic logic [D-1:0] m_mask();
    logic [D-1:0] m = '0;
    foreach (pos_q[j]) m[pos_q[j]] = 1'b1;
    return m;
  endfunction

  // Model update on the clock edge, using pre-edge inputs and model state.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q.delete();
      exp_q.delete();
    end else begin
      bit pop;
      bit acc;
      int lim;
      pop = m_out_valid() && out_ready;
      acc = in_valid && m_in_ready();
      if (flush) begin
        pos_q.delete();
        exp_q.delete();
      end else begin
        if (pop) void'(pos_q.pop_front());
        lim = D - 1;
        for (int j = 0; j < pos_q.size(); j++) begin
          pos_q[j] = (pos_q[j] + 1 < lim) ? pos_q[j] + 1 : lim;
          lim = pos_q[j] - 1;
        end
        if (acc) begin
          pos_q.push_back(0);
          exp_q.push_back({in_ctrl, in_data});
        end
      end
    end
  end

  // Monitor: compares every live cycle, pops the scoreboard on each handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", 128'(out_valid), 128'(m_out_valid()));
      chk("in_ready", 128'(in_ready), 128'(m_in_ready()));
      chk("occupancy", 128'(occupancy), 128'(pos_q.size()));
      chk("slot_valid", 128'(slot_valid), 128'(m_mask()));
      if (!out_valid) chk("out_ctrl_idle", 128'(out_ctrl), 128'(0));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 128'(1), 128'(0));
        end else begin
          logic [CTRL_W+DATA_W-1:0] e;
          e = exp_q.pop_front();
          $display("pop ctrl=%0h data=%0h expected ctrl=%0h data=%0h",
                   out_ctrl, out_data, e[CTRL_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
          chk("out_bundle", 128'({out_ctrl, out_data}), 128'(e));
        end
      end
    end
  end

  task automatic cyc(input bit iv, input bit orr, input bit fl);
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    in_valid  = iv;
    out_ready = orr;
    flush     = fl;
    in_ctrl   = fix_ctrl ? fix_val : 3'($urandom_range(7));
    in_data   = r[DATA_W-1:0];
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    #3;
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_occupancy", 128'(occupancy), 128'(0));
    chk("reset_slot_valid", 128'(slot_valid), 128'(0));
    chk("reset_out_ctrl", 128'(out_ctrl), 128'(0));
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Stream at full rate.
    repeat (6) cyc(1, 1, 0);
    repeat (3) cyc(0, 1, 0);

    // Backpressure then release.
    repeat (4) cyc(1, 0, 0);
    repeat (4) cyc(0, 1, 0);

    // Bubble collapse: A, gap, B while stalled.
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (2) cyc(0, 0, 0);
    chk("bubble_parked", 128'(slot_valid), 128'(2'b11));
    repeat (3) cyc(0, 1, 0);

    // Flush while full with all-commit control; an incoming bundle is dropped.
    fix_ctrl = 1'b1;
    fix_val  = 3'b101;
    repeat (2) cyc(1, 0, 0);
    cyc(1, 0, 1);
    fix_ctrl = 1'b0;
    chk("flush_out_valid", 128'(out_valid), 128'(0));
    chk("flush_out_ctrl", 128'(out_ctrl), 128'(0));
    repeat (3) cyc(0, 1, 0);

    // Pop and push together while full.
    repeat (2) cyc(1, 0, 0);
    repeat (4) cyc(1, 1, 0);
    repeat (3) cyc(0, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(3) != 0), ($urandom_range(2) != 0), ($urandom_range(24) == 0));
    end

    // Asynchronous reset between edges.
    repeat (3) cyc(1, 0, 0);
    #3 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("async_out_valid", 128'(out_valid), 128'(0));
    chk("async_occupancy", 128'(occupancy), 128'(0));
    chk("async_slot_valid", 128'(slot_valid), 128'(0));
    chk("async_out_data", 128'(out_data), 128'(0));
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1, 1, 0);
    chk("latency_not_yet", 128'(out_valid), 128'(0));
    cyc(0, 1, 0);
    chk("latency_arrived", 128'(out_valid), 128'(1));
    repeat (4) cyc(0, 1, 0);

    chk("drain_empty", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
